// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a synchronous FIFO and re-presents its words as a valid/ready stream via a 2-entry buffer
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic              i_force,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_rddata,
    input  logic              i_empty,
    input  logic              i_alm_empty,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_rd_count
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            state, state_next;
    logic [1:0]        occ;
    logic              infl;
    logic              head, tail;
    logic [DATA_W-1:0] buf_q [2];
    logic              pop;

    assign pop     = o_valid & i_ready;
    assign o_valid = (occ != 2'd0);
    assign o_data  = buf_q[head];
    assign o_busy  = (state != IDLE);
    // a read is only issued when the buffer is sure to have room for it, counting the word already in flight
    assign o_rden  = (state == STREAM) & i_en & ~i_empty & (3'(occ) + 3'(infl) < 3'd2 + 3'(pop));

    // next-state: start on enough data (or forced), drain on disable, idle once nothing is left
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (i_en & (~i_alm_empty | (i_force & ~i_empty))) ? STREAM : IDLE;
            STREAM:  state_next = ~i_en ? DRAIN : (i_empty & ~infl & (occ == 2'd0)) ? IDLE : STREAM;
            DRAIN:   state_next = (~infl & (occ == 2'd0) & ~o_rden) ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // state, in-flight flag, output buffer and delivered-word counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            occ        <= 2'd0;
            infl       <= 1'b0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            o_rd_count <= '0;
        end else begin
            state <= state_next;
            infl  <= o_rden;
            occ   <= occ + 2'(infl) - 2'(pop);
            if (infl) begin
                buf_q[tail] <= i_rddata;
                tail        <= ~tail;
            end
            if (pop) begin
                head       <= ~head;
                o_rd_count <= o_rd_count + CNT_W'(1);
            end
        end
    end
endmodule
